// File: rtl/row_normalizer_pkg.sv
// ---------------------------------------------------------------------------
// row_normalizer_pkg
// Shared definitions for the attention output normalizer:
//   - q_width():    total width of a signed Qm.n fixed-point format
//   - acc_q98_t:    signed Q9.8 accumulator / denominator word (NUM_W bits)
//   - mem_q07_t:    signed Q0.7 memory-format element (OUT_W bits)
//   - norm_state_e: normalizer FSM states
// ---------------------------------------------------------------------------
package row_normalizer_pkg;

   // Sign bit + integer bits + fraction bits.
   function automatic int unsigned q_width(input int unsigned int_bits,
                                           input int unsigned frac_bits);
      return 1 + int_bits + frac_bits;
   endfunction

   localparam int unsigned NUM_W = q_width(9, 8);
   localparam int unsigned OUT_W = q_width(0, 7);
   localparam int unsigned FRAC  = OUT_W - 1;

   // Magnitudes need one extra bit: |-2^17| = 2^17 does not fit in NUM_W unsigned-safe bits.
   localparam int unsigned REM_W = NUM_W + 1;

   typedef logic signed [NUM_W-1:0] acc_q98_t;
   typedef logic signed [OUT_W-1:0] mem_q07_t;

   localparam mem_q07_t SatPos = {1'b0, {(OUT_W-1){1'b1}}};
   localparam mem_q07_t SatNeg = {1'b1, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      StIdle,
      StDiv,
      StOut
   } norm_state_e;

endpackage

// File: rtl/row_normalizer_div_step.sv
// ---------------------------------------------------------------------------
// row_normalizer_div_step
// One combinational step of unsigned restoring division. The partial
// remainder is doubled and the divisor subtracted when it fits.
// Ports:
//   rem_i   current partial remainder (must be < den_i)
//   den_i   divisor (positive)
//   rem_o   next partial remainder (always < den_i)
//   qbit_o  quotient bit produced by this step
// ---------------------------------------------------------------------------
module row_normalizer_div_step
   import row_normalizer_pkg::*;
#(
   parameter int unsigned RemW = REM_W
) (
   input  logic [RemW-1:0] rem_i,
   input  logic [RemW-1:0] den_i,
   output logic [RemW-1:0] rem_o,
   output logic            qbit_o
);

   logic [RemW:0] shifted;
   logic [RemW:0] den_ext;
   logic [RemW:0] diff;

   always_comb begin
      shifted = {rem_i, 1'b0};
      den_ext = {1'b0, den_i};
      diff    = shifted - den_ext;
      qbit_o  = (shifted >= den_ext);
      // Both candidates are below den_i here, so the top bit is always zero.
      rem_o   = qbit_o ? diff[RemW-1:0] : shifted[RemW-1:0];
   end

endmodule

// File: rtl/row_normalizer.sv
// ---------------------------------------------------------------------------
// row_normalizer
// Divides each Q9.8 numerator of a row by the row's Q9.8 softmax denominator
// and returns a Q0.7 memory-format element. One quotient bit per cycle.
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   numerator (and denominator on element 0) valid
//   in_ready_o   high only in IDLE and not in reset
//   in_num_i     signed Q9.8 numerator
//   in_den_i     signed Q9.8 denominator, sampled only for element index 0
//   out_valid_o  result valid (held until out_ready_i)
//   out_ready_i  downstream accepts result
//   out_data_o   signed Q0.7 quotient, truncated toward zero, saturated
//   out_last_o   presented result is element D-1 of the row
//   out_err_o    row denominator was <= 0 (result forced to 0)
// ---------------------------------------------------------------------------
module row_normalizer
   import row_normalizer_pkg::*;
#(
   parameter int unsigned D = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [NUM_W-1:0] in_num_i,
   input  logic [NUM_W-1:0] in_den_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] out_data_o,
   output logic             out_last_o,
   output logic             out_err_o
);

   localparam int unsigned IdxW = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned CntW = $clog2(FRAC);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(D - 1);
   localparam logic [CntW-1:0] CntStart = CntW'(FRAC - 1);

   norm_state_e      state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   acc_q98_t         den_q, den_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [FRAC-1:0]  q_q, q_d;
   logic             sign_q, sign_d;
   logic [CntW-1:0]  bitcnt_q, bitcnt_d;
   mem_q07_t         data_q, data_d;
   logic             err_q, err_d;

   // Accept-time decode
   logic             accept;
   acc_q98_t         den_sel;
   logic             den_bad;
   logic [REM_W-1:0] num_ext;
   logic [REM_W-1:0] mag;
   logic [REM_W-1:0] den_mag_sel;

   // Iterated division step
   logic [REM_W-1:0] den_mag_q;
   logic [REM_W-1:0] step_rem;
   logic             step_qbit;
   logic [FRAC-1:0]  q_full;
   mem_q07_t         q_ext;
   mem_q07_t         q_signed;

   assign in_ready_o  = (state_q == StIdle) && !rst_i;
   assign accept      = in_valid_i && in_ready_o;
   assign out_valid_o = (state_q == StOut);
   assign out_data_o  = data_q;
   assign out_last_o  = out_valid_o && (idx_q == IdxLast);
   assign out_err_o   = err_q;

   always_comb begin
      // The row's first element brings its own denominator; later ones reuse it.
      den_sel     = (idx_q == '0) ? acc_q98_t'(in_den_i) : den_q;
      den_bad     = den_sel[NUM_W-1] || (den_sel == '0);
      den_mag_sel = {1'b0, den_sel};
      num_ext     = {in_num_i[NUM_W-1], in_num_i};
      mag         = in_num_i[NUM_W-1] ? (REM_W'(0) - num_ext) : num_ext;
   end

   assign den_mag_q = {1'b0, den_q};

   row_normalizer_div_step #(
      .RemW (REM_W)
   ) u_div_step (
      .rem_i  (rem_q),
      .den_i  (den_mag_q),
      .rem_o  (step_rem),
      .qbit_o (step_qbit)
   );

   always_comb begin
      // Quotient as it stands once the final (bit 0) step is merged in.
      q_full    = q_q;
      q_full[0] = step_qbit;
      q_ext     = {1'b0, q_full};
      q_signed  = sign_q ? (mem_q07_t'(0) - q_ext) : q_ext;
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      den_d    = den_q;
      rem_d    = rem_q;
      q_d      = q_q;
      sign_d   = sign_q;
      bitcnt_d = bitcnt_q;
      data_d   = data_q;
      err_d    = err_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (idx_q == '0) begin
                  den_d = acc_q98_t'(in_den_i);
               end
               sign_d = in_num_i[NUM_W-1];
               q_d    = '0;
               if (den_bad) begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = StOut;
               end else if (mag >= den_mag_sel) begin
                  // |num/den| >= 1 cannot be represented in Q0.7.
                  data_d  = in_num_i[NUM_W-1] ? SatNeg : SatPos;
                  err_d   = 1'b0;
                  state_d = StOut;
               end else begin
                  rem_d    = mag;
                  bitcnt_d = CntStart;
                  err_d    = 1'b0;
                  state_d  = StDiv;
               end
            end
         end

         StDiv: begin
            rem_d         = step_rem;
            q_d[bitcnt_q] = step_qbit;
            if (bitcnt_q == '0) begin
               data_d  = q_signed;
               state_d = StOut;
            end else begin
               bitcnt_d = bitcnt_q - CntW'(1);
            end
         end

         StOut: begin
            if (out_ready_i) begin
               idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         den_q    <= '0;
         rem_q    <= '0;
         q_q      <= '0;
         sign_q   <= 1'b0;
         bitcnt_q <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         den_q    <= den_d;
         rem_q    <= rem_d;
         q_q      <= q_d;
         sign_q   <= sign_d;
         bitcnt_q <= bitcnt_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_row_normalizer.sv
// ---------------------------------------------------------------------------
// tb_row_normalizer
// Directed bench for row_normalizer with D=4. A model computes each result
// from plain integer division of the row's rules; a compare process checks
// every presented output against it, and literal tables pin the model.
// ---------------------------------------------------------------------------
module tb_row_normalizer;

   localparam int unsigned TbD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [17:0] in_num = '0;
   logic [17:0] in_den = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_err;

   row_normalizer #(
      .D (TbD)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_num_i    (in_num),
      .in_den_i    (in_den),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .out_err_o   (out_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic       err;
      logic       last;
      int         acc_cyc;
      int         lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   logic seen = 1'b0;
   int   m_idx = 0;
   int   m_den = 0;
   logic [7:0] last_data = '0;
   logic       last_err = 1'b0;
   logic       last_last = 1'b0;

   // Directed vectors: numerator, denominator, expected Q0.7, expected err.
   int tn[32] = '{128, -128, 256, -300,   100, -100, -256, 0,
                  -256, 1, 255, -131072,  5, -7, 0, 1000,
                  256, -512, 511, -1,     192, -192, 384, 100,
                  384, -768, 100, -1000,  10, -10, 0, 70000};
   int td[32] = '{256, 999, 0, -1,        300, 5, 7, 1,
                  256, 0, 0, 0,           0, 300, 0, 256,
                  512, 0, 3, 3,           384, 0, 0, 0,
                  768, 1, 1, 1,           -5, 0, 0, 0};
   int te[32] = '{8'h40, 8'hC0, 8'h7F, 8'h80,  8'h2A, 8'hD6, 8'h93, 8'h00,
                  8'h80, 8'h00, 8'h7F, 8'h80,  8'h00, 8'h00, 8'h00, 8'h00,
                  8'h40, 8'h80, 8'h7F, 8'h00,  8'h40, 8'hC0, 8'h7F, 8'h21,
                  8'h40, 8'h80, 8'h10, 8'h80,  8'h00, 8'h00, 8'h00, 8'h00};
   int terr[32] = '{0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 1,
                    0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 1, 1};

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no event within bound, want one", name);
   endtask

   // Result, error flag and latency (accept cycle to first valid cycle).
   function automatic void model(input int num, input int den, output logic [7:0] d,
                                 output logic e, output int lat);
      int mag;
      int q;
      d   = '0;
      e   = 1'b0;
      lat = 8;
      if (den <= 0) begin
         e   = 1'b1;
         lat = 1;
      end else begin
         mag = (num < 0) ? -num : num;
         if (mag >= den) begin
            d   = (num < 0) ? 8'h80 : 8'h7F;
            lat = 1;
         end else begin
            q = (mag * 128) / den;
            d = (num < 0) ? 8'(-q) : 8'(q);
         end
      end
   endfunction

   task automatic send(input int num, input int den);
      int n = 0;
      exp_t e;
      logic [7:0] d;
      logic er;
      int lat;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         fail("in_ready_wait");
         return;
      end
      in_valid = 1'b1;
      in_num   = 18'(num);
      in_den   = 18'(den);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_den   = 18'h2AAAA;
      if (m_idx == 0) m_den = den;
      model(num, m_den, d, er, lat);
      e.data    = d;
      e.err     = er;
      e.last    = (m_idx == TbD - 1);
      e.acc_cyc = cyc - 1;
      e.lat     = lat;
      exp_q.push_back(e);
      m_idx = (m_idx + 1) % TbD;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         fail("drain_wait");
         exp_q.delete();
         seen = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      seen  = 1'b0;
      m_idx = 0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_out_data", out_data, 0);
      chk("post_rst_out_last", out_last, 0);
      chk("post_rst_out_err", out_err, 0);
   endtask

   task automatic run_vec(input int i);
      send(tn[i], td[i]);
      drain();
      chk($sformatf("lit_data_v%0d", i), last_data, te[i]);
      chk($sformatf("lit_err_v%0d", i), last_err, terr[i]);
      chk($sformatf("lit_last_v%0d", i), last_last, ((i % TbD) == TbD - 1) ? 1 : 0);
   endtask

   // Compare process: every presented output against the head of the model queue.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            cur = exp_q[0];
            if (!seen) begin
               chk("latency", cyc - cur.acc_cyc, cur.lat);
               seen = 1'b1;
            end
            chk("out_data", out_data, cur.data);
            chk("out_err", out_err, cur.err);
            chk("out_last", out_last, cur.last);
            chk("in_ready_busy", in_ready, 0);
            if (out_ready) begin
               last_data = out_data;
               last_err  = out_err;
               last_last = out_last;
               void'(exp_q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 20; i++) run_vec(i);

      // Backpressure: hold out_ready low with a competing input offered.
      send(tn[20], td[20]);
      out_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) fail("bp_out_valid_wait");
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_num   = 18'(1000);
      repeat (5) begin
         @(negedge clk);
         chk("bp_out_data", out_data, te[20]);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      chk("bp_lit_data", last_data, te[20]);
      for (int i = 21; i < 24; i++) run_vec(i);

      // Reset during the third division cycle of a fresh row.
      send(128, 256);
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      for (int i = 24; i < 32; i++) run_vec(i);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time limit, want finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/row_normalizer.md
# row_normalizer

Final-stage normalizer of the attention datapath: takes each row's accumulated output numerators (Q9.8) and the row's softmax denominator (Q9.8) and produces memory-format Q0.7 output elements. It is the inverse end of the fixed-point widening chain: it consumes the widest format and returns to the 8-bit storage format. Division is sequential (one quotient bit per cycle) behind valid/ready handshakes on both sides.

## Interface
- D, 64, elements per row; the denominator is latched once per row
- NUM_W, 18, width of Q9.8 numerator/denominator
- OUT_W, 8, width of Q0.7 output
- FRAC, 7, quotient fractional bits (OUT_W-1)
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  numerator (and, on row's first element, denominator) valid
- in_ready  out  1  block can accept an element
- in_num  in  NUM_W  signed Q9.8 numerator
- in_den  in  NUM_W  signed Q9.8 denominator; sampled only on element index 0
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  OUT_W  signed Q0.7 quotient
- out_last  out  1  result is element D-1 of the row
- out_err  out  1  row denominator was <= 0

## Operation
- FSM states IDLE, DIV, OUT. in_ready = (state==IDLE) && !reset; no input skid.
- IDLE: on in_valid&&in_ready accept. If idx==0, latch den from in_den, else reuse latched den. Latch sign and mag=|num| (NUM_W bits, -2^17 maps to 2^17 in NUM_W+1 bits).
- Decision at accept: den<=0 -> result 0, err=1, go OUT. mag>=den -> saturate (+127 if positive, -128 if negative), err=0, go OUT. Otherwise rem=mag, bitcnt=FRAC-1, go DIV.
- DIV (exactly FRAC cycles): rem<<=1; if rem>=den {rem-=den; q[bitcnt]=1} else q[bitcnt]=0; after bit 0, form result = sign ? -q : q, go OUT.
- Quotient is floor(|num|*128/den) with sign applied afterwards (truncation toward zero); range -127..127 on non-saturated path.
- OUT: out_valid=1, out_data/out_last/out_err stable until out_ready. On handshake: idx = (idx==D-1) ? 0 : idx+1, go IDLE.
- out_last = (idx==D-1) for the element being presented.
- err sticks for all D elements of a row whose denominator was <= 0.

## Timing
- Reset: state IDLE, idx 0, out_valid 0, out_data 0, out_last 0, out_err 0, latched den 0, in_ready 0 during reset cycle, 1 the cycle after.
- Normal path: accept in cycle t, DIV in t+1..t+7, out_valid in t+8. Fast path (saturate/err): out_valid in t+1.
- Best-case throughput: one element per 9 cycles (normal), per 2 cycles (fast), with out_ready held high.
- Backpressure: out_valid held and outputs frozen while out_ready=0; in_ready stays 0.
- in_valid in non-IDLE states is ignored (not consumed).
- Reset mid-DIV or mid-OUT: partial result discarded, idx returns to 0, next accepted element starts a new row.
- Row boundary: element after the D-1 handshake resamples in_den.

## Structure
- Shared package: Q-format width helper, Q9.8 accumulator type (NUM_W=18), Q0.7 memory type (OUT_W=8), normalizer FSM state enum.
- Sub-module div_step: combinational restoring step (rem, den) -> (rem_next, qbit); instantiated once, iterated by the FSM.
- Top holds FSM, idx counter (clog2(D) bits), den/rem/q/sign registers.

## Test plan
- den=256 (1.0), num=128 (0.5) -> out_data=0x40 (64) at t+8; num=-128 -> 0xC0 (-64).
- den=300, num=100 -> 42 (floor 42.67); num=-100 -> -42 (0xD6).
- den=256, num=256 -> 127 at t+1; num=-300 -> -128 (0x80) at t+1; num=-256 -> -128.
- D=4 row with den=0 -> four outputs 0 with out_err=1, out_last on 4th; next row den=512, num=256 -> 64, out_err=0.
- out_ready low 5 cycles in OUT -> out_data stable, in_ready 0, no extra input consumed; D=4 row confirms idx wrap and den resample.
- reset asserted during DIV cycle 3 -> next cycle out_valid 0, in_ready 1, idx 0; fresh row completes correctly.
